// File: rtl/paicore_recv_pkg.sv
// Shared types for the PAICORE receive session controller: FSM states,
// completion status codes and a saturating increment helper.
package paicore_recv_pkg;

  localparam int unsigned STATUS_W = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RECV,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [STATUS_W-1:0] ST_NONE      = 3'd0;
  localparam logic [STATUS_W-1:0] ST_COUNT     = 3'd1;
  localparam logic [STATUS_W-1:0] ST_TIMEOUT   = 3'd2;
  localparam logic [STATUS_W-1:0] ST_ABORT     = 3'd3;
  localparam logic [STATUS_W-1:0] ST_DRAIN_ERR = 3'd4;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/paicore_recv_sched_timer.sv
// Saturating cycle counter with synchronous clear, count enable and an
// equality compare against a loadable limit.
module recv_idle_timer
  import paicore_recv_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] limit,
  output logic             hit
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (enable && (count != '1)) begin
      count <= count + WIDTH'(1);
    end
  end

  assign hit = (count == limit);

endmodule

// File: rtl/paicore_recv_sched.sv
// Receive session controller: arms, counts join-output frames, ends on
// count/timeout/abort, drains the transport. Optional perf counters under
// PAICORE_RECV_SCHED_PERF_EN.
module paicore_recv_sched
  import paicore_recv_pkg::*;
#(
  parameter int unsigned CHANNEL   = 4,
  parameter int unsigned DRAIN_MAX = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [31:0]         frame_num_max,
  input  logic [31:0]         idle_timeout,
  input  logic [CHANNEL-1:0]  ch_request,
  input  logic                mon_tvalid,
  input  logic                mon_tready,
  input  logic                rx_done,
  output logic                recv_busy,
  output logic                recv_done,
  output logic                rx_rcving,
  output logic [31:0]         frame_cnt,
  output logic [STATUS_W-1:0] status,
  output logic                irq,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_stalls
);

  state_t               state_q, state_n;
  logic [31:0]          max_q, tmo_q;
  logic [31:0]          cnt_inc, cnt_n;
  logic [STATUS_W-1:0]  status_n;
  logic                 busy_n, done_n, rcving_n, irq_n;
  logic                 handshake, activity;
  logic                 idle_hit, drain_hit;

  assign handshake = mon_tvalid & mon_tready;
  assign activity  = handshake | (|ch_request);
  assign cnt_inc   = handshake ? sat_inc32(frame_cnt) : frame_cnt;

  recv_idle_timer #(.WIDTH(32)) u_idle_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  ((state_q != S_RECV) || activity),
    .enable (state_q == S_RECV),
    .limit  (tmo_q - 32'd1),
    .hit    (idle_hit)
  );

  recv_idle_timer #(.WIDTH(32)) u_drain_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (state_q != S_DRAIN),
    .enable (state_q == S_DRAIN),
    .limit  (32'(DRAIN_MAX - 1)),
    .hit    (drain_hit)
  );

  always_comb begin
    state_n  = state_q;
    status_n = status;
    cnt_n    = frame_cnt;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_n = S_ARM;
      end
      S_ARM: begin
        status_n = ST_NONE;
        cnt_n    = '0;
        state_n  = S_RECV;
      end
      S_RECV: begin
        cnt_n = cnt_inc;
        if (abort) begin
          status_n = ST_ABORT;
          state_n  = S_DRAIN;
        end else if ((max_q != '0) && handshake && (cnt_inc == max_q)) begin
          status_n = ST_COUNT;
          state_n  = S_DRAIN;
        end else if ((tmo_q != '0) && idle_hit && !activity) begin
          status_n = ST_TIMEOUT;
          state_n  = S_DRAIN;
        end
      end
      S_DRAIN: begin
        cnt_n = cnt_inc;
        if (abort) begin
          status_n = ST_ABORT;
          state_n  = S_DONE;
        end else if (rx_done) begin
          state_n  = S_DONE;
        end else if (drain_hit) begin
          status_n = ST_DRAIN_ERR;
          state_n  = S_DONE;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    // Outputs are decoded from the next state so the flops present them
    // in the same cycle the state register enters that state.
    busy_n   = (state_n == S_RECV);
    rcving_n = (state_n == S_RECV) || (state_n == S_DRAIN);
    done_n   = (state_n == S_DRAIN) && (state_q != S_DRAIN);
    irq_n    = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      max_q     <= '0;
      tmo_q     <= '0;
      frame_cnt <= '0;
      status    <= ST_NONE;
      recv_busy <= 1'b0;
      recv_done <= 1'b0;
      rx_rcving <= 1'b0;
      irq       <= 1'b0;
    end else begin
      state_q   <= state_n;
      frame_cnt <= cnt_n;
      status    <= status_n;
      recv_busy <= busy_n;
      recv_done <= done_n;
      rx_rcving <= rcving_n;
      irq       <= irq_n;
      if (state_q == S_ARM) begin
        max_q <= frame_num_max;
        tmo_q <= idle_timeout;
      end
    end
  end

`ifdef PAICORE_RECV_SCHED_PERF_EN
  logic [31:0] cyc_q, stall_q;
  logic        active;

  assign active = (state_q == S_RECV) || (state_q == S_DRAIN);

  always_ff @(posedge clk) begin
    if (rst || (state_q == S_ARM)) begin
      cyc_q   <= '0;
      stall_q <= '0;
    end else if (active) begin
      cyc_q <= sat_inc32(cyc_q);
      if (mon_tvalid && !mon_tready) stall_q <= sat_inc32(stall_q);
    end
  end

  assign perf_cycles = cyc_q;
  assign perf_stalls = stall_q;
`else
  assign perf_cycles = '0;
  assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_paicore_recv_sched.sv
// Self-checking bench for paicore_recv_sched: session vector table plus a
// completion scoreboard checked on every irq pulse.
module tb_paicore_recv_sched;
  import paicore_recv_pkg::*;

  localparam int unsigned DRAIN_N = 16;

  logic        clk = 1'b0;
  logic        rst, start, abort, mon_tvalid, mon_tready, rx_done;
  logic [31:0] frame_num_max, idle_timeout;
  logic [3:0]  ch_request;
  logic        recv_busy, recv_done, rx_rcving, irq;
  logic [31:0] frame_cnt, perf_cycles, perf_stalls;
  logic [2:0]  status;

  always #5 clk = ~clk;

  paicore_recv_sched #(.CHANNEL(4), .DRAIN_MAX(DRAIN_N)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .frame_num_max(frame_num_max), .idle_timeout(idle_timeout),
    .ch_request(ch_request), .mon_tvalid(mon_tvalid), .mon_tready(mon_tready),
    .rx_done(rx_done), .recv_busy(recv_busy), .recv_done(recv_done),
    .rx_rcving(rx_rcving), .frame_cnt(frame_cnt), .status(status), .irq(irq),
    .perf_cycles(perf_cycles), .perf_stalls(perf_stalls)
  );

  typedef struct {
    int max; int tmo; int nfr; int req_only; int stall; int abort_last;
    int start_mid; int abort_start; int drain_fr; int dabort; int rxd;
    int st; int cnt; int lat;
  } vec_t;

  typedef struct {
    logic [2:0]  st;
    logic [31:0] cnt;
    logic [31:0] stalls;
  } exp_t;

  int   n_vec = 0;
  int   n_bad = 0;
  int   irq_cnt = 0;
  exp_t sb[$];
  exp_t e_pop;
  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (irq === 1'b1) begin
      irq_cnt++;
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL irq_unexpected: got irq=1 expected no completion");
      end else begin
        e_pop = sb.pop_front();
        chk("sb_status", 32'(status), 32'(e_pop.st));
        chk("sb_frame_cnt", frame_cnt, e_pop.cnt);
        chk("sb_perf_stalls", perf_stalls, e_pop.stalls);
      end
    end
  end

  task automatic run_vec(input vec_t v);
    int lat;
    int t;
    int irq0;
    int irq_exp;
    logic [31:0] stalls_exp;
    logic [31:0] cyc_exp;
    irq_exp = (v.dabort != 0) ? 1 : ((v.rxd < 0) ? int'(DRAIN_N) : v.rxd + 1);
`ifdef PAICORE_RECV_SCHED_PERF_EN
    stalls_exp = 32'(v.stall);
    cyc_exp    = 32'(v.stall + v.nfr + v.lat + irq_exp);
`else
    stalls_exp = '0;
    cyc_exp    = '0;
`endif
    irq0          = irq_cnt;
    frame_num_max = 32'(v.max);
    idle_timeout  = 32'(v.tmo);
    start         = 1'b1;
    abort         = (v.abort_start != 0);
    sb.push_back(exp_t'{3'(v.st), 32'(v.cnt), stalls_exp});
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("arm_busy", 32'(recv_busy), 32'd0);
    tick;
    chk("recv_busy", 32'(recv_busy), 32'd1);
    chk("recv_rcving", 32'(rx_rcving), 32'd1);
    for (int s = 0; s < v.stall; s++) begin
      mon_tvalid = 1'b1;
      mon_tready = 1'b0;
      tick;
    end
    for (int i = 0; i < v.nfr; i++) begin
      if (v.req_only != 0) begin
        mon_tvalid = 1'b0;
        mon_tready = 1'b0;
        ch_request = 4'b0001 << (i % 4);
      end else begin
        mon_tvalid = 1'b1;
        mon_tready = 1'b1;
      end
      abort = (v.abort_last != 0) && (i == v.nfr - 1);
      start = (v.start_mid != 0) && (i == 2);
      tick;
    end
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    ch_request = '0;
    abort      = 1'b0;
    start      = 1'b0;
    lat = 0;
    while (recv_done !== 1'b1 && lat < 200) begin
      tick;
      lat++;
    end
    chk("done_latency", 32'(lat), 32'(v.lat));
    chk("drain_busy", 32'(recv_busy), 32'd0);
    chk("drain_rcving", 32'(rx_rcving), 32'd1);
    t = 0;
    while (irq !== 1'b1 && t < 100) begin
      rx_done    = (v.rxd >= 0) && (t >= v.rxd);
      mon_tvalid = (t < v.drain_fr);
      mon_tready = (t < v.drain_fr);
      abort      = (v.dabort != 0) && (t == 0);
      tick;
      t++;
      if (t == 1) chk("done_pulse_width", 32'(recv_done), 32'd0);
    end
    rx_done    = 1'b0;
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    abort      = 1'b0;
    chk("irq_latency", 32'(t), 32'(irq_exp));
    chk("done_rcving", 32'(rx_rcving), 32'd0);
    chk("perf_cycles", perf_cycles, cyc_exp);
    tick;
    chk("irq_pulse_width", 32'(irq), 32'd0);
    chk("hold_frame_cnt", frame_cnt, 32'(v.cnt));
    chk("hold_status", 32'(status), 32'(v.st));
    chk("irq_once", 32'(irq_cnt - irq0), 32'd1);
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    //            max tmo nfr req stl abl smd abs dfr dab rxd  st cnt lat
    vecs[0] = '{  8,  0,  8,  0,  0,  0,  1,  0,  0,  0,  2,  1,  8,  0};
    vecs[1] = '{  0, 20,  3,  0,  0,  0,  0,  0,  0,  0,  0,  2,  3, 20};
    vecs[2] = '{  5,  0,  5,  0,  0,  1,  0,  0,  0,  0,  1,  3,  5,  0};
    vecs[3] = '{  4,  0,  4,  0,  0,  0,  0,  0,  2,  0, -1,  4,  6,  0};
    vecs[4] = '{ 10,  0, 10,  0,  4,  0,  0,  1,  0,  0,  0,  1, 10,  0};
    vecs[5] = '{  0,  1,  0,  0,  0,  0,  0,  0,  0,  0,  0,  2,  0,  1};
    vecs[6] = '{  0,  6,  4,  1,  0,  0,  0,  0,  0,  0,  3,  2,  0,  6};
    vecs[7] = '{  3,  2,  3,  0,  0,  0,  0,  0,  0,  0,  0,  1,  3,  0};
    vecs[8] = '{  2,  0,  2,  0,  0,  0,  0,  0,  0,  1, -1,  3,  2,  0};

    rst = 1'b1; start = 1'b0; abort = 1'b0; rx_done = 1'b0;
    mon_tvalid = 1'b0; mon_tready = 1'b0; ch_request = '0;
    frame_num_max = '0; idle_timeout = '0;
    repeat (3) tick;
    rst = 1'b0;
    chk("reset_busy", 32'(recv_busy), 32'd0);
    chk("reset_rcving", 32'(rx_rcving), 32'd0);
    chk("reset_done", 32'(recv_done), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    chk("reset_frame_cnt", frame_cnt, 32'd0);
    chk("reset_status", 32'(status), 32'd0);
    chk("reset_perf", perf_cycles | perf_stalls, 32'd0);

    for (int k = 0; k < 9; k++) begin
      run_vec(vecs[k]);
      repeat (2) tick;
    end

    // Reset in the middle of an unlimited session with 5 frames counted.
    frame_num_max = '0;
    idle_timeout  = '0;
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    for (int i = 0; i < 5; i++) begin
      mon_tvalid = 1'b1;
      mon_tready = 1'b1;
      tick;
    end
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    chk("midrst_frames", frame_cnt, 32'd5);
    begin
      int irq_before;
      irq_before = irq_cnt;
      rst = 1'b1;
      tick;
      rst = 1'b0;
      chk("midrst_busy", 32'(recv_busy), 32'd0);
      chk("midrst_rcving", 32'(rx_rcving), 32'd0);
      chk("midrst_done", 32'(recv_done), 32'd0);
      chk("midrst_frame_cnt", frame_cnt, 32'd0);
      chk("midrst_status", 32'(status), 32'd0);
      chk("midrst_perf", perf_cycles | perf_stalls, 32'd0);
      repeat (25) tick;
      chk("midrst_no_irq", 32'(irq_cnt - irq_before), 32'd0);
    end
    run_vec(vecs[7]);
    repeat (2) tick;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
